conv_window_mac: RTL and testbench

- Consumer stage directly downstream of the cyclic sample queue in the convolution accelerator.
- Drains samples from the queue with the queue's read handshake (En=1, mode=0) and keeps a TAPS-deep sliding window.
- Computes one valid-mode 1-D convolution output per window position against a locally stored kernel.
- Streams results downstream with a valid/ready handshake.

---
 rtl/conv_window_mac.sv | 162 ++++++++++++++++
 tb/tb_conv_window_mac.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_mac.sv
// Sliding-window 1-D convolution MAC: drains the sample queue, keeps a TAPS-deep
// window and streams one valid-mode result per window position.
module conv_window_mac #(
   parameter int DATA_W = 32,
   parameter int W_W    = 16,
   parameter int TAPS   = 3,
   parameter int ACC_W  = 64,
   parameter int LEN_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         len,
   input  logic                     w_we,
   input  logic [$clog2(TAPS)-1:0]  w_addr,
   input  logic [W_W-1:0]           w_data,
   input  logic                     q_empty,
   input  logic [DATA_W-1:0]        q_data,
   output logic                     q_en,
   output logic                     q_mode,
   output logic [ACC_W-1:0]         res_data,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic                     busy,
   output logic                     done
);
   localparam int PW = DATA_W + W_W;
   localparam logic [LEN_W-1:0] TAPS_L  = LEN_W'(TAPS);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                   state_q, state_d;
   logic [LEN_W-1:0]         n_q, n_d, issued_q, issued_d, recv_q, recv_d;
   logic signed [DATA_W-1:0] win_q [TAPS];
   logic signed [DATA_W-1:0] win_d [TAPS];
   logic signed [W_W-1:0]    w_q [TAPS];
   logic signed [W_W-1:0]    w_d [TAPS];
   logic signed [DATA_W-1:0] hold_q, hold_d, shift_in;
   logic                     hold_vld_q, hold_vld_d, rd_pend_q, rd_pend_d;
   logic signed [ACC_W-1:0]  res_q, res_d, acc;
   logic                     res_valid_q, res_valid_d, done_q, done_d;
   logic                     adv, shift_en, q_en_c;

   // Sign-extend a full-precision product, then wrap it to the accumulator width.
   function automatic logic signed [ACC_W-1:0] wrap_prod(input logic signed [PW-1:0] p);
      logic [ACC_W+PW-1:0] ext;
      ext = {{ACC_W{p[PW-1]}}, p};
      return ext[ACC_W-1:0];
   endfunction

   always_comb begin
      adv      = !res_valid_q || res_ready;
      q_en_c   = (state_q == RUN) && !q_empty && (issued_q < n_q) && adv && !hold_vld_q;
      shift_en = adv && (rd_pend_q || hold_vld_q);
      shift_in = hold_vld_q ? hold_q : q_data;

      state_d     = state_q;
      n_d         = n_q;
      issued_d    = q_en_c ? issued_q + LEN_ONE : issued_q;
      recv_d      = recv_q;
      win_d       = win_q;
      w_d         = w_q;
      hold_d      = hold_q;
      hold_vld_d  = hold_vld_q;
      rd_pend_d   = q_en_c;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      done_d      = 1'b0;

      // A sample arriving while the output is stalled parks in the hold register.
      if (rd_pend_q && !adv) begin
         hold_d     = q_data;
         hold_vld_d = 1'b1;
      end else if (shift_en && hold_vld_q) begin
         hold_vld_d = 1'b0;
      end

      if (shift_en) begin
         for (int k = 0; k < TAPS - 1; k++) win_d[k] = win_q[k+1];
         win_d[TAPS-1] = shift_in;
         recv_d        = recv_q + LEN_ONE;
      end

      acc = '0;
      for (int k = 0; k < TAPS; k++)
         acc = acc + wrap_prod(PW'(win_d[k]) * PW'(w_q[k]));

      // A new result loading on the same edge as an acceptance keeps res_valid high.
      if (shift_en && (recv_d >= TAPS_L)) begin
         res_d       = acc;
         res_valid_d = 1'b1;
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (w_we && (int'(w_addr) < TAPS)) w_d[w_addr] = w_data;
            if (start) begin
               if (len >= TAPS_L) begin
                  state_d  = RUN;
                  n_d      = len;
                  issued_d = '0;
                  recv_d   = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (issued_q == n_q) state_d = DRAIN;
         end
         DRAIN: begin
            if ((recv_q == n_q) && res_valid_q && res_ready) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         n_q         <= '0;
         issued_q    <= '0;
         recv_q      <= '0;
         for (int k = 0; k < TAPS; k++) begin
            win_q[k] <= '0;
            w_q[k]   <= '0;
         end
         hold_q      <= '0;
         hold_vld_q  <= 1'b0;
         rd_pend_q   <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         issued_q    <= issued_d;
         recv_q      <= recv_d;
         win_q       <= win_d;
         w_q         <= w_d;
         hold_q      <= hold_d;
         hold_vld_q  <= hold_vld_d;
         rd_pend_q   <= rd_pend_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         done_q      <= done_d;
      end
   end

   assign q_en      = q_en_c;
   assign q_mode    = 1'b0;
   assign res_data  = res_q;
   assign res_valid = res_valid_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac with a behavioural sample-queue model.
module tb_conv_window_mac;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] len = '0;
   logic        w_we = 1'b0;
   logic [1:0]  w_addr = '0;
   logic [15:0] w_data = '0;
   logic        q_empty;
   logic [31:0] q_data = '0;
   logic        q_en, q_mode;
   logic [63:0] res_data;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic        busy, done;

   int checks = 0;
   int failures = 0;

   int          cyc = 0;
   logic [31:0] mem [64];
   int          q_rd = 0;
   int          q_top = 0;
   bit          gate = 1'b0;

   logic [63:0] got [8];
   int          gotc [8];
   int          ng, nq, nd, bad, first_q, first_v, done_c, stall_bad, stalled;
   bit          timed_out;

   conv_window_mac dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .q_empty(q_empty), .q_data(q_data), .q_en(q_en), .q_mode(q_mode),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   assign q_empty = (q_rd >= q_top) || gate;

   // Queue model: Data_Out is valid the cycle after a read request.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (q_en) begin
         q_data <= mem[q_rd % 64];
         q_rd   <= q_rd + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic load_weights(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      logic [15:0] w [3];
      w[0] = a; w[1] = b; w[2] = c;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         w_we = 1'b1; w_addr = 2'(k); w_data = w[k];
      end
      @(posedge clk); #1;
      w_we = 1'b0;
   endtask

   task automatic load_ramp(input int n);
      for (int k = 0; k < n; k++) mem[(q_rd + k) % 64] = 32'(k + 1);
      q_top = q_rd + n;
   endtask

   task automatic run_job(input int ln, input bit stall, input bit toggle, input bit poke, input int abort_at);
      ng = 0; nq = 0; nd = 0; bad = 0; first_q = -1; first_v = -1; done_c = -1;
      stall_bad = 0; stalled = 0; timed_out = 1'b1;
      @(posedge clk); #1;
      res_ready = !stall; gate = 1'b0; start = 1'b1; len = ln[15:0];
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (q_en) begin
            if (first_q < 0) first_q = cyc;
            nq++;
            if (q_empty) bad++;
         end
         if (res_valid && first_v < 0) first_v = cyc;
         if (stall && res_valid && !res_ready) begin
            stalled++;
            if (res_data !== 64'd14 || q_en !== 1'b0) stall_bad++;
         end
         if (res_valid && res_ready) begin
            if (ng < 8) begin got[ng] = res_data; gotc[ng] = cyc; end
            ng++;
         end
         if (done) begin nd++; done_c = cyc; timed_out = 1'b0; break; end
         if (abort_at > 0 && ng >= abort_at) begin timed_out = 1'b0; break; end
         @(posedge clk); #1;
         start = 1'b0; w_we = 1'b0;
         if (stall && stalled >= 5) res_ready = 1'b1;
         if (toggle && (i % 2 == 1)) gate = !gate;
         if (poke && i == 2) begin
            start = 1'b1; len = 16'd3; w_we = 1'b1; w_addr = 2'd0; w_data = 16'd100;
         end
      end
      start = 1'b0; w_we = 1'b0; gate = 1'b0; res_ready = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (q_en !== 1'b0) begin failures++; $display("FAIL reset_q_en: got %b expected 0", q_en); end
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (res_data !== 64'd0) begin failures++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
      checks++; if (q_mode !== 1'b0) begin failures++; $display("FAIL reset_q_mode: got %b expected 0", q_mode); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [63:0] exp_r [3];
      exp_r[0] = 64'd14; exp_r[1] = 64'd20; exp_r[2] = 64'd26;
      load_weights(16'd1, 16'd2, 16'd3);
      load_ramp(5);
      run_job(5, 1'b0, 1'b0, 1'b0, 0);
      checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout: got no done expected done"); end
      checks++; if (ng !== 3) begin failures++; $display("FAIL basic_count: got %0d expected 3", ng); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got[k] !== exp_r[k]) begin failures++; $display("FAIL basic_res%0d: got %0d expected %0d", k, got[k], exp_r[k]); end
      end
      checks++; if (gotc[1] !== gotc[0] + 1 || gotc[2] !== gotc[0] + 2) begin
         failures++; $display("FAIL basic_back_to_back: got cycles %0d,%0d,%0d expected consecutive", gotc[0], gotc[1], gotc[2]); end
      checks++; if (first_v - first_q !== 4) begin failures++; $display("FAIL basic_latency: got %0d expected 4", first_v - first_q); end
      checks++; if (nq !== 5) begin failures++; $display("FAIL basic_reads: got %0d expected 5", nq); end
      checks++; if (done_c !== gotc[2] + 1) begin failures++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_c, gotc[2] + 1); end
   endtask

   task automatic test_stall();
      logic [63:0] exp_r [3];
      exp_r[0] = 64'd14; exp_r[1] = 64'd20; exp_r[2] = 64'd26;
      load_ramp(5);
      run_job(5, 1'b1, 1'b0, 1'b0, 0);
      checks++; if (timed_out || ng !== 3) begin failures++; $display("FAIL stall_count: got %0d expected 3", ng); end
      checks++; if (stalled !== 5) begin failures++; $display("FAIL stall_cycles: got %0d expected 5", stalled); end
      checks++; if (stall_bad !== 0) begin failures++; $display("FAIL stall_hold: got %0d bad cycles expected 0", stall_bad); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got[k] !== exp_r[k]) begin failures++; $display("FAIL stall_res%0d: got %0d expected %0d", k, got[k], exp_r[k]); end
      end
      checks++; if (nq !== 5) begin failures++; $display("FAIL stall_reads: got %0d expected 5", nq); end
   endtask

   task automatic test_empty_toggle();
      logic [63:0] exp_r [3];
      exp_r[0] = 64'd14; exp_r[1] = 64'd20; exp_r[2] = 64'd26;
      load_ramp(5);
      run_job(5, 1'b0, 1'b1, 1'b0, 0);
      checks++; if (timed_out || ng !== 3) begin failures++; $display("FAIL toggle_count: got %0d expected 3", ng); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL toggle_read_when_empty: got %0d expected 0", bad); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got[k] !== exp_r[k]) begin failures++; $display("FAIL toggle_res%0d: got %0d expected %0d", k, got[k], exp_r[k]); end
      end
   endtask

   task automatic test_start_while_busy();
      logic [63:0] exp_r [3];
      exp_r[0] = 64'd14; exp_r[1] = 64'd20; exp_r[2] = 64'd26;
      load_ramp(5);
      run_job(5, 1'b0, 1'b0, 1'b1, 0);
      checks++; if (timed_out || ng !== 3) begin failures++; $display("FAIL busy_count: got %0d expected 3", ng); end
      checks++; if (nq !== 5) begin failures++; $display("FAIL busy_reads: got %0d expected 5", nq); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got[k] !== exp_r[k]) begin failures++; $display("FAIL busy_res%0d: got %0d expected %0d", k, got[k], exp_r[k]); end
      end
   endtask

   task automatic test_signed_wrap();
      load_weights(16'hFFFF, 16'd0, 16'd0);
      mem[q_rd % 64]       = 32'h8000_0000;
      mem[(q_rd + 1) % 64] = 32'd5;
      mem[(q_rd + 2) % 64] = 32'd7;
      q_top = q_rd + 3;
      run_job(3, 1'b0, 1'b0, 1'b0, 0);
      checks++; if (timed_out || ng !== 1) begin failures++; $display("FAIL signed_count: got %0d expected 1", ng); end
      checks++; if (got[0] !== 64'h0000_0000_8000_0000) begin
         failures++; $display("FAIL signed_res: got %h expected 0000000080000000", got[0]); end
   endtask

   task automatic test_short_len();
      int q0;
      q0 = q_rd;
      @(posedge clk); #1;
      start = 1'b1; len = 16'd2;
      @(negedge clk);
      checks++; if (q_en !== 1'b0) begin failures++; $display("FAIL short_q_en: got %b expected 0", q_en); end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL short_done: got %b expected 1", done); end
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL short_idle: got res_valid=%b busy=%b expected 0,0", res_valid, busy); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL short_done_pulse: got %b expected 0", done); end
      checks++; if (q_rd !== q0) begin failures++; $display("FAIL short_reads: got %0d expected 0", q_rd - q0); end
   endtask

   task automatic test_reset_mid_run();
      load_weights(16'd1, 16'd2, 16'd3);
      load_ramp(8);
      run_job(8, 1'b0, 1'b0, 1'b0, 2);
      checks++; if (timed_out || got[0] !== 64'd14 || got[1] !== 64'd20) begin
         failures++; $display("FAIL midrst_pre: got %0d,%0d expected 14,20", got[0], got[1]); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy: got %b expected 1", busy); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({q_en, res_valid, busy, done} !== 4'b0000 || res_data !== 64'd0) begin
         failures++; $display("FAIL midrst_outputs: got q_en=%b vld=%b busy=%b done=%b data=%h expected all 0",
                              q_en, res_valid, busy, done, res_data); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_no_done: got %b expected 0", done); end
      load_ramp(5);
      run_job(5, 1'b0, 1'b0, 1'b0, 0);
      checks++; if (timed_out || ng !== 3) begin failures++; $display("FAIL midrst_job_count: got %0d expected 3", ng); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got[k] !== 64'd0) begin failures++; $display("FAIL midrst_zero%0d: got %0d expected 0", k, got[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_empty_toggle();
      test_start_while_busy();
      test_signed_wrap();
      test_short_len();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
